// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider producing one quotient bit per clock.
// A start/busy/done handshake frames each operation. quotient, remainder and
// div_by_zero are registered and hold between operations.
// Optional build macro SEQ_DIVIDER_SIGNED_EN: two's complement operands and results.
// The sign handling wraps the same unsigned core.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one quotient bit per edge, then one cycle to register the results
// DONE  | single-cycle done pulse; a new start is accepted here as in IDLE
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] dvsr_q;
    logic [WIDTH:0]   part_q;
    logic [CW-1:0]    cnt_q;
    logic             fin_q;

    logic             accept;
    logic [WIDTH:0]   p_val;
    logic [WIDTH:0]   p_diff;
    logic             p_ge;
    logic             dz;
    logic [WIDTH-1:0] load_dvd;
    logic [WIDTH-1:0] load_dvs;

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic q_neg_q;
    logic r_neg_q;

    // The core always sees magnitudes; most-negative maps onto itself, which
    // reads correctly as an unsigned 2^(WIDTH-1).
    assign load_dvd = dividend[WIDTH-1] ? (~dividend + ONE) : dividend;
    assign load_dvs = divisor[WIDTH-1]  ? (~divisor + ONE)  : divisor;
`else
    assign load_dvd = dividend;
    assign load_dvs = divisor;
`endif

    assign accept = start && ((state == IDLE) || (state == DONE));
    assign dz     = (dvsr_q == '0);

    // One restoring step: P = {partial, next dividend bit}, subtract if it fits.
    assign p_val  = (part_q << 1) | {{WIDTH{1'b0}}, shift_q[WIDTH-1]};
    assign p_ge   = (p_val >= {1'b0, dvsr_q});
    assign p_diff = p_val - {1'b0, dvsr_q};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and handshake outputs. The result-registering cycle at the
    // end of RUN is not reported as busy.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (accept) state_nxt = RUN;
            RUN: begin
                busy = !fin_q;
                if (fin_q) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = accept ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture and iteration datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            dvsr_q  <= '0;
            part_q  <= '0;
            cnt_q   <= '0;
            fin_q   <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
`endif
        end else if (accept) begin
            shift_q <= load_dvd;
            dvsr_q  <= load_dvs;
            part_q  <= '0;
            cnt_q   <= CW'(WIDTH - 1);
            fin_q   <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            q_neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_neg_q <= dividend[WIDTH-1];
`endif
        end else if ((state == RUN) && !fin_q) begin
            part_q  <= p_ge ? p_diff : p_val;
            shift_q <= {shift_q[WIDTH-2:0], p_ge};
            if (cnt_q == '0) fin_q <= 1'b1;
            else             cnt_q <= cnt_q - 1'b1;
        end
    end

    // Result registers, loaded only on the edge that enters DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if ((state == RUN) && fin_q) begin
`ifdef SEQ_DIVIDER_SIGNED_EN
            quotient    <= dz ? '1 : (q_neg_q ? (~shift_q + ONE) : shift_q);
            remainder   <= r_neg_q ? (~part_q[WIDTH-1:0] + ONE) : part_q[WIDTH-1:0];
`else
            quotient    <= shift_q;
            remainder   <= part_q[WIDTH-1:0];
`endif
            div_by_zero <= dz;
        end
    end

endmodule
